// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//   On-chip self-test for a 2..8-input combinational gate. It walks every
//   input vector in ascending order and holds each one for SETTLE cycles. It
//   then samples the gate output for one cycle and compares it with the
//   selected logic function. It records the mismatch count, the first failing
//   vector and an overall pass flag.
//
// Ports
//   i_clk         rising-edge clock
//   i_rst_n       asynchronous active-low reset
//   i_start       run request, honoured only while idle
//   i_func_sel    0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 AND
//   i_dut_out     gate output under test (looked at only in SAMPLE)
//   o_stim        vector driven to the gate
//   o_busy        run in progress
//   o_done        one-cycle pulse at the end of a run
//   o_pass        last run had zero mismatches (held until next start)
//   o_err_count   mismatches in the current/last run
//   o_fail_valid  o_fail_vec holds a captured vector
//   o_fail_vec    first vector that mismatched
module gate_vector_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_func_sel,
    input  logic            i_dut_out,
    output logic [N_IN-1:0] o_stim,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [N_IN:0]   o_err_count,
    output logic            o_fail_valid,
    output logic [N_IN-1:0] o_fail_vec
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

    // SETTLE=1 still needs a 1-bit counter (it only ever holds 0).
    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t          r_state, w_next;
    logic [2:0]      r_sel;
    logic [CW-1:0]   r_cnt;
    logic [N_IN-1:0] r_stim, r_fail_vec;
    logic [N_IN:0]   r_err;
    logic            r_busy, r_done, r_pass, r_fail_valid;

    logic            w_exp, w_mismatch, w_last;
    logic [N_IN:0]   w_err_inc;

    // Expected gate response for the vector currently on o_stim.
    always_comb begin
        w_exp = &r_stim;
        case (r_sel)
            3'd1:    w_exp =  |r_stim;
            3'd2:    w_exp =  ^r_stim;
            3'd3:    w_exp = ~&r_stim;
            3'd4:    w_exp = ~|r_stim;
            3'd5:    w_exp = ~^r_stim;
            default: w_exp =  &r_stim;
        endcase
    end

    assign w_mismatch = (i_dut_out != w_exp);
    assign w_last     = (r_stim == LAST_VEC);
    // Count including the current sample, so the final pass flag sees it.
    assign w_err_inc  = r_err + (N_IN+1)'(w_mismatch);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start)       w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == '0)   w_next = S_SAMPLE;
            S_SAMPLE: w_next = w_last ? S_IDLE : S_SETTLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel        <= '0;
            r_cnt        <= '0;
            r_stim       <= '0;
            r_err        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sel        <= i_func_sel;
                        r_stim       <= '0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_cnt        <= CNT_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_SAMPLE: begin
                    r_err <= w_err_inc;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_vec   <= r_stim;
                        r_fail_valid <= 1'b1;
                    end
                    if (!w_last) begin
                        r_stim <= r_stim + 1'b1;
                        r_cnt  <= CNT_LOAD;
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_inc == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stim       = r_stim;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err;
    assign o_fail_valid = r_fail_valid;
    assign o_fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker
//   Two checker instances share clock and reset: A (N_IN=2, SETTLE=2) and
//   B (N_IN=3, SETTLE=1). A configurable gate model feeds each one. The gate
//   model is a reference function, optionally tied to a constant or with
//   per-vector flips. The expected run result is computed from a walk over
//   all vectors using ones-counting.
module tb_gate_vector_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_start, a_out, a_busy, a_done, a_pass, a_fv;
    logic [2:0] a_sel, a_err;
    logic [1:0] a_stim, a_fvec;

    logic       b_start, b_out, b_busy, b_done, b_pass, b_fv;
    logic [2:0] b_sel, b_stim, b_fvec;
    logic [3:0] b_err;

    gate_vector_checker #(.N_IN(2), .SETTLE(2)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_func_sel(a_sel),
        .i_dut_out(a_out), .o_stim(a_stim), .o_busy(a_busy), .o_done(a_done),
        .o_pass(a_pass), .o_err_count(a_err), .o_fail_valid(a_fv),
        .o_fail_vec(a_fvec));

    gate_vector_checker #(.N_IN(3), .SETTLE(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_func_sel(b_sel),
        .i_dut_out(b_out), .o_stim(b_stim), .o_busy(b_busy), .o_done(b_done),
        .o_pass(b_pass), .o_err_count(b_err), .o_fail_valid(b_fv),
        .o_fail_vec(b_fvec));

    // Gate model configuration
    int           g_fn;
    logic [255:0] g_flip;
    bit           g_tie, g_tie_val;

    function automatic bit ref_fn(input int fn, input int v, input int n);
        int ones;
        ones = $countones(v);
        case (fn)
            1:       return ones != 0;
            2:       return (ones % 2) == 1;
            3:       return ones != n;
            4:       return ones == 0;
            5:       return (ones % 2) == 0;
            default: return ones == n;
        endcase
    endfunction

    assign a_out = g_tie ? g_tie_val : (ref_fn(g_fn, int'(a_stim), 2) ^ g_flip[a_stim]);
    assign b_out = g_tie ? g_tie_val : (ref_fn(g_fn, int'(b_stim), 3) ^ g_flip[b_stim]);

    // View of the instance currently under test
    int         inst;
    logic [7:0] c_stim, c_fvec;
    logic [8:0] c_err;
    logic       c_busy, c_done, c_pass, c_fv;
    always_comb begin
        c_stim = (inst == 1) ? {5'b0, b_stim} : {6'b0, a_stim};
        c_fvec = (inst == 1) ? {5'b0, b_fvec} : {6'b0, a_fvec};
        c_err  = (inst == 1) ? {5'b0, b_err}  : {6'b0, a_err};
        c_busy = (inst == 1) ? b_busy : a_busy;
        c_done = (inst == 1) ? b_done : a_done;
        c_pass = (inst == 1) ? b_pass : a_pass;
        c_fv   = (inst == 1) ? b_fv   : a_fv;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t inst=%0d)", tag, got, exp, $time, inst);
        end
    endtask

    task automatic set_start(input bit v);
        if (inst == 1) b_start = v; else a_start = v;
    endtask

    task automatic set_sel(input int v);
        if (inst == 1) b_sel = 3'(v); else a_sel = 3'(v);
    endtask

    // One complete run on the current instance, with cycle-accurate checks.
    task automatic run(input int fn, input bit perturb, input bit hold);
        int n, s, nv, len, e_err, e_fvec;
        bit e_fv, g, seen;
        n   = (inst == 1) ? 3 : 2;
        s   = (inst == 1) ? 1 : 2;
        nv  = 1 << n;
        len = nv * (s + 1);
        e_err = 0; e_fvec = 0; e_fv = 1'b0;
        for (int v = 0; v < nv; v++) begin
            g = g_tie ? g_tie_val : (ref_fn(g_fn, v, n) ^ g_flip[v]);
            if (g != ref_fn(fn, v, n)) begin
                if (!e_fv) begin e_fv = 1'b1; e_fvec = v; end
                e_err++;
            end
        end

        @(negedge clk);
        set_sel(fn);
        set_start(1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(1'b0);
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            if (k < len) begin
                chk("busy", 32'(c_busy), 1);
                chk("done_early", 32'(c_done), 0);
                chk("stim", 32'(c_stim), 32'(k / (s + 1)));
                if (perturb) begin
                    set_start(1'($urandom_range(0, 1)));
                    set_sel(int'($urandom_range(0, 7)));
                end
            end else begin
                chk("done", 32'(c_done), 1);
                chk("busy_end", 32'(c_busy), 0);
                chk("err_count", 32'(c_err), 32'(e_err));
                chk("fail_valid", 32'(c_fv), 32'(e_fv));
                chk("fail_vec", 32'(c_fvec), 32'(e_fvec));
                chk("pass", 32'(c_pass), 32'(e_err == 0));
                if (!hold) set_start(1'b0);
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(c_done), 0);
        if (hold) begin
            chk("hold_busy", 32'(c_busy), 1);
            chk("hold_stim", 32'(c_stim), 0);
            set_start(1'b0);
            seen = 1'b0;
            for (int i = 0; i < len + 4 && !seen; i++) begin
                @(negedge clk);
                seen = c_done;
            end
            chk("hold_rerun_done", 32'(seen), 1);
            chk("hold_rerun_err", 32'(c_err), 32'(e_err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dones;
        logic [8:0] keep_err;
        rst_n = 1'b1;
        a_start = 1'b0; b_start = 1'b0; a_sel = '0; b_sel = '0;
        g_fn = 0; g_flip = '0; g_tie = 1'b0; g_tie_val = 1'b0; inst = 0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_stim", 32'(a_stim), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_pass", 32'(a_pass), 0);
        chk("rst_err", 32'(a_err), 0);
        chk("rst_fv", 32'(a_fv), 0);
        chk("rst_fvec", 32'(a_fvec), 0);
        chk("rst_b_busy", 32'(b_busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Correct AND model, AND selected
        run(0, 1'b0, 1'b0);
        // Idle with start low: results hold
        keep_err = c_err;
        repeat (3) @(negedge clk);
        chk("idle_pass", 32'(c_pass), 1);
        chk("idle_err", 32'(c_err), 32'(keep_err));
        chk("idle_busy", 32'(c_busy), 0);

        // AND model against OR
        run(1, 1'b0, 1'b0);
        // Output tied high against NAND, then a correct NAND
        g_tie = 1'b1; g_tie_val = 1'b1;
        run(3, 1'b0, 1'b0);
        g_tie = 1'b0; g_fn = 3;
        run(3, 1'b0, 1'b0);
        // Start and func_sel toggling mid-run
        g_fn = 0;
        run(0, 1'b1, 1'b0);

        // Reset during vector 10
        @(negedge clk);
        a_sel = 3'd0; a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_stim", 32'(a_stim), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stim", 32'(a_stim), 0);
        chk("arst_busy", 32'(a_busy), 0);
        chk("arst_err", 32'(a_err), 0);
        chk("arst_pass", 32'(a_pass), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (a_done) dones++;
        end
        chk("arst_no_done", 32'(dones), 0);
        chk("arst_idle", 32'(a_busy), 0);
        run(0, 1'b0, 1'b0);

        // start held high: back-to-back runs
        run(0, 1'b0, 1'b1);

        // Wider instance, XOR
        inst = 1; g_fn = 2;
        run(2, 1'b0, 1'b0);

        // Randomized configurations on both instances
        for (int r = 0; r < 24; r++) begin
            inst      = int'($urandom_range(0, 1));
            g_fn      = int'($urandom_range(0, 5));
            g_flip    = ($urandom_range(0, 2) == 0) ? '0 : 256'($urandom_range(0, 255));
            g_tie     = ($urandom_range(0, 5) == 0);
            g_tie_val = 1'($urandom_range(0, 1));
            run(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
